// File: rtl/mips_writeback_unit.sv
// rtl/mips_writeback_unit.sv - in-order write-back queue feeding the register file write port
module mips_writeback_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic                          mem_valid,
  input  logic [ADDR_WIDTH-1:0]         mem_dest,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  output logic                          mem_ready,
  input  logic                          alu_valid,
  input  logic [ADDR_WIDTH-1:0]         alu_dest,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  output logic                          alu_ready,
  output logic                          RegWrite,
  output logic [ADDR_WIDTH-1:0]         WriteAddress,
  output logic [DATA_WIDTH-1:0]         DataIn,
  output logic [2**ADDR_WIDTH-1:0]      pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = CW + 1;

  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         alu_slot;
  logic [FIFO_DEPTH-1:0] valid_q;
  logic [ADDR_WIDTH-1:0] dest_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [FW-1:0]         free;
  logic                  pop;
  logic                  mem_push;
  logic                  alu_push;
  logic [1:0]            n_push;

  // Pointers wrap modulo FIFO_DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Free slots count the head as reusable because it always pops this edge.
  always_comb begin
    pop       = (fifo_count != '0);
    free      = FW'(FIFO_DEPTH) - {1'b0, fifo_count} + {{CW{1'b0}}, pop};
    mem_ready = !rst && (free >= FW'(1));
    alu_ready = !rst && (free >= FW'(2));
    // Writes to $0 complete the handshake but never enter the queue.
    mem_push  = mem_valid && mem_ready && (mem_dest != '0);
    alu_push  = alu_valid && alu_ready && (alu_dest != '0);
    // The load is older than the ALU op, so it takes the earlier slot.
    alu_slot  = mem_push ? ptr_inc(wr_ptr) : wr_ptr;
    n_push    = {1'b0, mem_push} + {1'b0, alu_push};
  end

  // Queue control: pointers, occupancy and per-slot valid flags.
  always_ff @(posedge CLK) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      valid_q    <= '0;
    end else begin
      // A push into the slot popped this edge must win, so pushes come last.
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= ptr_inc(rd_ptr);
      end
      if (mem_push) valid_q[wr_ptr]   <= 1'b1;
      if (alu_push) valid_q[alu_slot] <= 1'b1;
      if (alu_push) wr_ptr <= ptr_inc(alu_slot);
      else if (mem_push) wr_ptr <= ptr_inc(wr_ptr);
      fifo_count <= fifo_count + CW'(n_push) - CW'(pop);
    end
  end

  // Entry payload storage; pushes are already blocked while rst is high.
  always_ff @(posedge CLK) begin
    if (mem_push) begin
      dest_q[wr_ptr] <= mem_dest;
      data_q[wr_ptr] <= mem_data;
    end
    if (alu_push) begin
      dest_q[alu_slot] <= alu_dest;
      data_q[alu_slot] <= alu_data;
    end
  end

  // Write port comes straight from the head entry, zeroed when empty.
  always_comb begin
    RegWrite     = pop;
    WriteAddress = pop ? dest_q[rd_ptr] : '0;
    DataIn       = pop ? data_q[rd_ptr] : '0;
  end

  // Hazard bitmap: every live entry marks its destination register.
  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (valid_q[i]) pending[dest_q[i]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_writeback_unit.sv
// tb/tb_mips_writeback_unit.sv - randomized self-checking bench for mips_writeback_unit
module tb_mips_writeback_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;
  localparam int SW = 1 + AW + DW + 32 + 3 + 1 + 1;

  logic          CLK;
  logic          rst;
  logic          mem_valid;
  logic [AW-1:0] mem_dest;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          alu_valid;
  logic [AW-1:0] alu_dest;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          RegWrite;
  logic [AW-1:0] WriteAddress;
  logic [DW-1:0] DataIn;
  logic [31:0]   pending;
  logic [2:0]    fifo_count;

  mips_writeback_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .rst(rst),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .RegWrite(RegWrite), .WriteAddress(WriteAddress), .DataIn(DataIn),
    .pending(pending), .fifo_count(fifo_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] d;
    logic [DW-1:0] v;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  logic [SW-1:0] obs;
  assign obs = {RegWrite, WriteAddress, DataIn, pending, fifo_count, mem_ready, alu_ready};

  function automatic int model_free();
    int n = q.size();
    return DEPTH - n + ((n > 0) ? 1 : 0);
  endfunction

  function automatic logic [SW-1:0] exp_state();
    int n = q.size();
    logic [31:0] p = '0;
    logic [AW-1:0] hd = '0;
    logic [DW-1:0] hv = '0;
    foreach (q[i]) p[q[i].d] = 1'b1;
    if (n > 0) begin
      hd = q[0].d;
      hv = q[0].v;
    end
    return {n > 0, hd, hv, p, 3'(n), !rst && model_free() >= 1, !rst && model_free() >= 2};
  endfunction

  // One clock edge; the queue model follows the architectural rules.
  task automatic tick();
    int  n  = q.size();
    bit  ma = !rst && mem_valid && model_free() >= 1;
    bit  aa = !rst && alu_valid && model_free() >= 2;
    ent_t em = '{mem_dest, mem_data};
    ent_t ea = '{alu_dest, alu_data};
    @(posedge CLK);
    if (rst) q.delete();
    else begin
      if (n > 0) void'(q.pop_front());
      if (ma && em.d != 0) q.push_back(em);
      if (aa && ea.d != 0) q.push_back(ea);
    end
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 0; alu_valid = 0;
    mem_dest = '0; alu_dest = '0; mem_data = '0; alu_data = '0;
  endtask

  task automatic test_reset();
    rst = 1; mem_valid = 1; alu_valid = 1;
    mem_dest = 5'd3; alu_dest = 5'd4; mem_data = 32'h1; alu_data = 32'h2;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({mem_ready, alu_ready, RegWrite, fifo_count, pending} !== {1'b0, 1'b0, 1'b0, 3'd0, 32'd0}) begin
        errors++;
        $display("FAIL reset_hold cyc%0d got mr=%b ar=%b rw=%b cnt=%0d pend=%h want 0", c, mem_ready, alu_ready, RegWrite, fifo_count, pending);
      end
    end
    rst = 0; idle_inputs(); #1;
    checks++;
    if ({RegWrite, WriteAddress, DataIn, fifo_count, pending, mem_ready, alu_ready} !== {1'b0, 5'd0, 32'd0, 3'd0, 32'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_after got rw=%b wa=%0d di=%h cnt=%0d pend=%h mr=%b ar=%b want 0,0,0,0,0,1,1", RegWrite, WriteAddress, DataIn, fifo_count, pending, mem_ready, alu_ready);
    end
  endtask

  task automatic test_single_alu();
    alu_valid = 1; alu_dest = 5'd5; alu_data = 32'h12345678;
    tick();
    idle_inputs(); #1;
    checks++;
    if ({RegWrite, WriteAddress, DataIn, pending, fifo_count} !== {1'b1, 5'd5, 32'h12345678, 32'h20, 3'd1}) begin
      errors++;
      $display("FAIL single_alu_issue got rw=%b wa=%0d di=%h pend=%h cnt=%0d want 1,5,12345678,20,1", RegWrite, WriteAddress, DataIn, pending, fifo_count);
    end
    tick();
    checks++;
    if ({RegWrite, pending, fifo_count} !== {1'b0, 32'd0, 3'd0}) begin
      errors++;
      $display("FAIL single_alu_done got rw=%b pend=%h cnt=%0d want 0,0,0", RegWrite, pending, fifo_count);
    end
  endtask

  task automatic test_simultaneous();
    mem_valid = 1; mem_dest = 5'd8; mem_data = 32'hAAAA0000;
    alu_valid = 1; alu_dest = 5'd9; alu_data = 32'h0000BBBB;
    tick();
    idle_inputs(); #1;
    checks++;
    if ({RegWrite, WriteAddress, DataIn, pending, fifo_count} !== {1'b1, 5'd8, 32'hAAAA0000, 32'h300, 3'd2}) begin
      errors++;
      $display("FAIL simul_first got rw=%b wa=%0d di=%h pend=%h cnt=%0d want 1,8,aaaa0000,300,2", RegWrite, WriteAddress, DataIn, pending, fifo_count);
    end
    tick();
    checks++;
    if ({RegWrite, WriteAddress, DataIn, pending, fifo_count} !== {1'b1, 5'd9, 32'h0000BBBB, 32'h200, 3'd1}) begin
      errors++;
      $display("FAIL simul_second got rw=%b wa=%0d di=%h pend=%h cnt=%0d want 1,9,0000bbbb,200,1", RegWrite, WriteAddress, DataIn, pending, fifo_count);
    end
    tick();
    checks++;
    if ({RegWrite, pending} !== {1'b0, 32'd0}) begin
      errors++;
      $display("FAIL simul_drain got rw=%b pend=%h want 0,0", RegWrite, pending);
    end
  endtask

  task automatic test_back_to_back();
    int nxt = 1;
    int last = 0;
    for (int c = 0; c < 14; c++) begin
      mem_valid = 1; alu_valid = 1;
      mem_dest = 5'(nxt); alu_dest = 5'(nxt + 1);
      mem_data = 32'(nxt) * 32'h01010101; alu_data = 32'(nxt + 1) * 32'h01010101;
      #1;
      checks++;
      if (obs !== exp_state() || fifo_count > 3'd4) begin
        errors++;
        $display("FAIL backpressure cyc%0d got %h want %h", c, obs, exp_state());
      end
      if (RegWrite) begin
        checks++;
        if (int'(WriteAddress) != last + 1) begin
          errors++;
          $display("FAIL backpressure_order cyc%0d got reg %0d want reg %0d", c, WriteAddress, last + 1);
        end
        last = int'(WriteAddress);
      end
      nxt += (model_free() >= 2) ? 2 : 1;
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 8 && q.size() > 0; c++) tick();
    #1;
    checks++;
    if ({fifo_count, RegWrite, pending} !== {3'd0, 1'b0, 32'd0} || q.size() != 0) begin
      errors++;
      $display("FAIL backpressure_drain got cnt=%0d rw=%b pend=%h model=%0d want empty", fifo_count, RegWrite, pending, q.size());
    end
  endtask

  task automatic test_dest_zero();
    alu_valid = 1; alu_dest = 5'd0; alu_data = 32'hFFFFFFFF; #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL dest0_ready got %b want 1", alu_ready);
    end
    tick();
    idle_inputs(); #1;
    checks++;
    if ({RegWrite, pending, fifo_count} !== {1'b0, 32'd0, 3'd0}) begin
      errors++;
      $display("FAIL dest0_empty got rw=%b pend=%h cnt=%0d want 0,0,0", RegWrite, pending, fifo_count);
    end
    mem_valid = 1; mem_dest = 5'd7; mem_data = 32'h77;
    alu_valid = 1; alu_dest = 5'd0; alu_data = 32'hFFFFFFFF;
    tick();
    idle_inputs(); #1;
    checks++;
    if ({fifo_count, pending, WriteAddress} !== {3'd1, 32'h80, 5'd7}) begin
      errors++;
      $display("FAIL dest0_mixed got cnt=%0d pend=%h wa=%0d want 1,80,7", fifo_count, pending, WriteAddress);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    mem_valid = 1; mem_dest = 5'd2; mem_data = 32'h22;
    alu_valid = 1; alu_dest = 5'd3; alu_data = 32'h33;
    tick();
    mem_dest = 5'd4; mem_data = 32'h44; alu_dest = 5'd5; alu_data = 32'h55;
    tick();
    idle_inputs(); #1;
    checks++;
    if ({fifo_count, pending} !== {3'd3, 32'h38}) begin
      errors++;
      $display("FAIL rstmid_fill got cnt=%0d pend=%h want 3,38", fifo_count, pending);
    end
    rst = 1; mem_valid = 1; alu_valid = 1; mem_dest = 5'd6; alu_dest = 5'd7;
    tick();
    rst = 0; idle_inputs(); #1;
    checks++;
    if ({fifo_count, pending, RegWrite} !== {3'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_clear got cnt=%0d pend=%h rw=%b want 0,0,0", fifo_count, pending, RegWrite);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (RegWrite !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_nowrite cyc%0d got rw=%b wa=%0d want rw=0", c, RegWrite, WriteAddress);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 39) == 0);
      mem_valid = $urandom_range(0, 2) != 0;
      alu_valid = $urandom_range(0, 2) != 0;
      mem_dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mem_data  = $urandom;
      alu_data  = $urandom;
      #1;
      checks++;
      if (obs !== exp_state()) begin
        errors++;
        $display("FAIL random cyc%0d got %h want %h", c, obs, exp_state());
      end
      tick();
    end
    rst = 0; idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #1;
    test_reset();
    test_single_alu();
    test_simultaneous();
    test_back_to_back();
    test_dest_zero();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
